// File: rtl/register_file_mp.sv
// Multi-port register file: NRD combinational read ports, NWR synchronous write ports,
// optional same-cycle write->read bypass and a per-register busy scoreboard.
module register_file_mp #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH      = 5,
  parameter int unsigned NRD         = 4,
  parameter int unsigned NWR         = 2,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          ZERO_R0     = 1'b1,
  parameter bit          RESET_INDEX = 1'b1
) (
  input  logic                    r_clk,
  input  logic                    r_rst,
  input  logic [NWR-1:0]          r_wr_en,
  input  logic [NWR*AWIDTH-1:0]   r_wr_addr,
  input  logic [NWR*DWIDTH-1:0]   r_wr_data,
  input  logic [NWR-1:0]          r_al_en,
  input  logic [NWR*AWIDTH-1:0]   r_al_addr,
  input  logic [NRD*AWIDTH-1:0]   r_rd_addr,
  output logic [NRD*DWIDTH-1:0]   r_rd_data,
  output logic [NRD-1:0]          r_rd_busy,
  output logic [(2**AWIDTH)-1:0]  r_busy_vec
);

  localparam int unsigned Depth = 2 ** AWIDTH;

  logic [DWIDTH-1:0] regs_q [Depth];
  logic [DWIDTH-1:0] regs_d [Depth];
  logic [Depth-1:0]  busy_q;
  logic [Depth-1:0]  busy_d;
  logic [NWR-1:0]    wr_ok;
  logic [NWR-1:0]    al_ok;
  logic [NRD-1:0]    rd_wr_hit;
  logic [NRD-1:0]    rd_al_hit;

  // Register 0 is inert when hardwired: writes and allocates to it are dropped.
  always_comb begin
    wr_ok = '0;
    al_ok = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_ok[k] = r_wr_en[k] && !(ZERO_R0 && (r_wr_addr[k*AWIDTH +: AWIDTH] == '0));
      al_ok[k] = r_al_en[k] && !(ZERO_R0 && (r_al_addr[k*AWIDTH +: AWIDTH] == '0));
    end
  end

  // Ascending port order makes the highest index win a collision; allocates are applied
  // after writebacks so a new producer keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_ok[k]) begin
        regs_d[r_wr_addr[k*AWIDTH +: AWIDTH]] = r_wr_data[k*DWIDTH +: DWIDTH];
        busy_d[r_wr_addr[k*AWIDTH +: AWIDTH]] = 1'b0;
      end
    end
    for (int k = 0; k < NWR; k++) begin
      if (al_ok[k]) begin
        busy_d[r_al_addr[k*AWIDTH +: AWIDTH]] = 1'b1;
      end
    end
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= RESET_INDEX ? DWIDTH'(i) : '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    r_rd_data = '0;
    r_rd_busy = '0;
    rd_wr_hit = '0;
    rd_al_hit = '0;
    for (int j = 0; j < NRD; j++) begin
      r_rd_data[j*DWIDTH +: DWIDTH] = regs_q[r_rd_addr[j*AWIDTH +: AWIDTH]];
      r_rd_busy[j]                  = busy_q[r_rd_addr[j*AWIDTH +: AWIDTH]];
      if (BYPASS) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_ok[k] && (r_wr_addr[k*AWIDTH +: AWIDTH] == r_rd_addr[j*AWIDTH +: AWIDTH])) begin
            r_rd_data[j*DWIDTH +: DWIDTH] = r_wr_data[k*DWIDTH +: DWIDTH];
            rd_wr_hit[j]                  = 1'b1;
          end
          if (al_ok[k] && (r_al_addr[k*AWIDTH +: AWIDTH] == r_rd_addr[j*AWIDTH +: AWIDTH])) begin
            rd_al_hit[j] = 1'b1;
          end
        end
        // Value is available now unless a newer producer is claiming the register.
        if (rd_wr_hit[j] && !rd_al_hit[j]) begin
          r_rd_busy[j] = 1'b0;
        end
      end
    end
  end

  assign r_busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp with default parameters (bypass, zero r0,
// index reset) against an array-based reference model.
module tb_register_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int DEPTH = 32;

  logic                r_clk;
  logic                r_rst;
  logic [NWR-1:0]      r_wr_en;
  logic [NWR*AW-1:0]   r_wr_addr;
  logic [NWR*DW-1:0]   r_wr_data;
  logic [NWR-1:0]      r_al_en;
  logic [NWR*AW-1:0]   r_al_addr;
  logic [NRD*AW-1:0]   r_rd_addr;
  logic [NRD*DW-1:0]   r_rd_data;
  logic [NRD-1:0]      r_rd_busy;
  logic [DEPTH-1:0]    r_busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]    m_reg [DEPTH];
  logic [DEPTH-1:0] m_busy;

  register_file_mp dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .r_wr_en   (r_wr_en),
    .r_wr_addr (r_wr_addr),
    .r_wr_data (r_wr_data),
    .r_al_en   (r_al_en),
    .r_al_addr (r_al_addr),
    .r_rd_addr (r_rd_addr),
    .r_rd_data (r_rd_data),
    .r_rd_busy (r_rd_busy),
    .r_busy_vec(r_busy_vec)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_reg[i] = DW'(i);
    m_busy = '0;
  endtask

  function automatic int wa(int k); return int'(r_wr_addr[k*AW +: AW]); endfunction
  function automatic int aa(int k); return int'(r_al_addr[k*AW +: AW]); endfunction
  function automatic int ra(int j); return int'(r_rd_addr[j*AW +: AW]); endfunction

  // Expected read value: r0 is zero; otherwise the last (highest) port writing it, else stored.
  function automatic logic [DW-1:0] exp_data(int a);
    logic [DW-1:0] d;
    if (a == 0) return '0;
    d = m_reg[a];
    for (int k = 0; k < NWR; k++)
      if (r_wr_en[k] && wa(k) == a) d = r_wr_data[k*DW +: DW];
    return d;
  endfunction

  function automatic logic exp_busy(int a);
    bit w = 0;
    bit al = 0;
    if (a == 0) return 1'b0;
    for (int k = 0; k < NWR; k++) begin
      if (r_wr_en[k] && wa(k) == a) w = 1;
      if (r_al_en[k] && aa(k) == a) al = 1;
    end
    return (w && !al) ? 1'b0 : m_busy[a];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < NWR; k++)
      if (r_wr_en[k] && wa(k) != 0) begin
        m_reg[wa(k)]  = r_wr_data[k*DW +: DW];
        m_busy[wa(k)] = 1'b0;
      end
    for (int k = 0; k < NWR; k++)
      if (r_al_en[k] && aa(k) != 0) m_busy[aa(k)] = 1'b1;
  endtask

  task automatic tick();
    @(posedge r_clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    r_wr_en = '0; r_wr_addr = '0; r_wr_data = '0;
    r_al_en = '0; r_al_addr = '0;
  endtask

  task automatic set_rd(int a0, int a1, int a2, int a3);
    r_rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic test_reset();
    idle();
    set_rd(0, 5, 31, 7);
    #1;
    n_tests++;
    if (r_rd_data !== {32'd7, 32'd31, 32'd5, 32'd0}) begin
      n_fail++; $display("FAIL reset_data got %h want %h", r_rd_data, {32'd7, 32'd31, 32'd5, 32'd0});
    end
    n_tests++;
    if (r_busy_vec !== '0) begin
      n_fail++; $display("FAIL reset_busy got %h want 0", r_busy_vec);
    end
  endtask

  task automatic test_bypass();
    idle();
    r_wr_en = 2'b01; r_wr_addr[0 +: AW] = 5'd3; r_wr_data[0 +: DW] = 32'hDEAD_BEEF;
    set_rd(3, 3, 0, 1);
    #2;
    n_tests++;
    if (r_rd_data[0 +: DW] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass_same got %h want deadbeef", r_rd_data[0 +: DW]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (r_rd_data[DW +: DW] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass_next got %h want deadbeef", r_rd_data[DW +: DW]);
    end
  endtask

  task automatic test_collision();
    idle();
    r_wr_en = 2'b11;
    r_wr_addr = {5'd9, 5'd9};
    r_wr_data = {32'd2, 32'd1};
    set_rd(0, 0, 9, 0);
    #2;
    n_tests++;
    if (r_rd_data[2*DW +: DW] !== 32'd2) begin
      n_fail++; $display("FAIL collide_bypass got %0d want 2", r_rd_data[2*DW +: DW]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (r_rd_data[2*DW +: DW] !== 32'd2) begin
      n_fail++; $display("FAIL collide_store got %0d want 2", r_rd_data[2*DW +: DW]);
    end
  endtask

  task automatic test_busy();
    idle();
    set_rd(4, 0, 0, 0);
    r_al_en = 2'b01; r_al_addr[0 +: AW] = 5'd4;
    tick();
    idle();
    #1;
    n_tests++;
    if (r_busy_vec[4] !== 1'b1 || r_rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL busy_alloc got vec=%b rd=%b want 1,1", r_busy_vec[4], r_rd_busy[0]);
    end
    r_wr_en = 2'b10; r_wr_addr[AW +: AW] = 5'd4; r_wr_data[DW +: DW] = 32'h1234;
    #1;
    n_tests++;
    if (r_rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL busy_wr_bypass got %b want 0", r_rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (r_busy_vec[4] !== 1'b0) begin
      n_fail++; $display("FAIL busy_clear got %b want 0", r_busy_vec[4]);
    end
    r_al_en = 2'b01; r_al_addr[0 +: AW] = 5'd4;
    r_wr_en = 2'b10; r_wr_addr[AW +: AW] = 5'd4; r_wr_data[DW +: DW] = 32'd77;
    #1;
    n_tests++;
    if (r_rd_busy[0] !== 1'b0 || r_rd_data[0 +: DW] !== 32'd77) begin
      n_fail++; $display("FAIL busy_alwr_comb got busy=%b data=%0d want 0,77",
                         r_rd_busy[0], r_rd_data[0 +: DW]);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (r_busy_vec[4] !== 1'b1 || r_rd_data[0 +: DW] !== 32'd77) begin
      n_fail++; $display("FAIL busy_alwr got busy=%b data=%0d want 1,77",
                         r_busy_vec[4], r_rd_data[0 +: DW]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    r_wr_en = 2'b01; r_wr_addr[0 +: AW] = 5'd0; r_wr_data[0 +: DW] = 32'd5;
    r_al_en = 2'b10; r_al_addr[AW +: AW] = 5'd0;
    set_rd(0, 0, 0, 0);
    #1;
    n_tests++;
    if (r_rd_data !== '0 || r_rd_busy !== '0) begin
      n_fail++; $display("FAIL zero_comb got data=%h busy=%b want 0,0", r_rd_data, r_rd_busy);
    end
    tick();
    tick();
    idle();
    #1;
    n_tests++;
    if (r_rd_data[0 +: DW] !== '0 || r_busy_vec[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_after got data=%h busy=%b want 0,0",
                         r_rd_data[0 +: DW], r_busy_vec[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NWR; k++) begin
        r_wr_en[k]            = 1'($urandom_range(0, 1));
        r_wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        r_wr_data[k*DW +: DW] = $urandom;
        r_al_en[k]            = 1'($urandom_range(0, 2) == 0);
        r_al_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      for (int j = 0; j < NRD; j++)
        r_rd_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      #2;
      for (int j = 0; j < NRD; j++) begin
        n_tests++;
        if (r_rd_data[j*DW +: DW] !== exp_data(ra(j))) begin
          n_fail++; $display("FAIL rand_data c=%0d port=%0d addr=%0d got %h want %h",
                             c, j, ra(j), r_rd_data[j*DW +: DW], exp_data(ra(j)));
        end
        n_tests++;
        if (r_rd_busy[j] !== exp_busy(ra(j))) begin
          n_fail++; $display("FAIL rand_busy c=%0d port=%0d addr=%0d got %b want %b",
                             c, j, ra(j), r_rd_busy[j], exp_busy(ra(j)));
        end
      end
      n_tests++;
      if (r_busy_vec !== m_busy) begin
        n_fail++; $display("FAIL rand_busy_vec c=%0d got %h want %h", c, r_busy_vec, m_busy);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    r_wr_en = 2'b11; r_wr_addr = {5'd11, 5'd10}; r_wr_data = {32'hAAAA, 32'hBBBB};
    r_al_en = 2'b01; r_al_addr[0 +: AW] = 5'd12;
    tick();
    idle();
    #2;
    r_rst = 1'b0;
    model_reset();
    set_rd(10, 11, 12, 0);
    #1;
    n_tests++;
    if (r_rd_data !== {32'd0, 32'd12, 32'd11, 32'd10}) begin
      n_fail++; $display("FAIL async_rst_data got %h want %h", r_rd_data,
                         {32'd0, 32'd12, 32'd11, 32'd10});
    end
    n_tests++;
    if (r_busy_vec !== '0) begin
      n_fail++; $display("FAIL async_rst_busy got %h want 0", r_busy_vec);
    end
    #2;
    r_rst = 1'b1;
  endtask

  initial begin
    r_rst = 1'b0;
    idle();
    r_rd_addr = '0;
    model_reset();
    #12;
    r_rst = 1'b1;
    test_reset();
    tick();
    test_bypass();
    test_collision();
    test_busy();
    test_zero_reg();
    test_random();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
